// File: rtl/key_matrix_emulator.sv
// rtl/key_matrix_emulator.sv - scripted 4x6 keypad model with contact bounce for scanner loopback
module key_matrix_emulator #(
  parameter int BOUNCE_CYC = 2000,
  parameter int HOLD_UNIT  = 1000,
  parameter int GAP_CYC    = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_out,
  output logic [5:0]  key_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_code,
  input  logic [15:0] req_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAKE = 3'd1,
    S_HOLD = 3'd2,
    S_BRK  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [31:0] BOUNCE_LD   = 32'(BOUNCE_CYC - 1);
  localparam logic [31:0] GAP_LD      = 32'(GAP_CYC - 1);
  localparam logic [31:0] HOLD_UNIT_W = 32'(HOLD_UNIT);
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [4:0]  NUM_KEYS    = 5'd24;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        contact_q, contact_d;
  logic [4:0]  code_q, code_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;

  logic        accept;
  logic        code_legal;
  logic [15:0] lfsr_step;
  logic [31:0] hold_cycles;

  assign accept      = req_valid && (state_q == S_IDLE);
  assign code_legal  = (req_code < NUM_KEYS);
  // Right-shifting Fibonacci form of taps 16,14,13,11; bit 0 is the chatter source
  assign lfsr_step   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign hold_cycles = {16'd0, hold_q} * HOLD_UNIT_W;

  // State register: FSM, timer, chatter generator, contact and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      lfsr_q    <= LFSR_SEED;
      contact_q <= 1'b0;
      code_q    <= 5'd0;
      hold_q    <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      contact_q <= contact_d;
      code_q    <= code_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
    end
  end

  // Next-state: phase sequencing, timer reloads and contact level for the coming cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    code_d  = code_q;
    hold_d  = hold_q;
    err_d   = err_q;

    // The generator only runs while the contact is chattering, so each fresh
    // reset reproduces the same bounce pattern for the first press.
    if (state_q == S_MAKE || state_q == S_BRK) begin
      lfsr_d = lfsr_step;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          code_d = req_code;
          hold_d = (req_hold == 16'd0) ? 16'd1 : req_hold;
          if (code_legal) begin
            state_d = S_MAKE;
            cnt_d   = BOUNCE_LD;
            err_d   = 1'b0;
          end else begin
            // No key to press: skip straight to the quiet gap so done still pulses
            state_d = S_GAP;
            cnt_d   = GAP_LD;
            err_d   = 1'b1;
          end
        end
      end
      S_MAKE: begin
        if (cnt_q == 32'd0) begin
          state_d = S_HOLD;
          cnt_d   = hold_cycles - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 32'd0) begin
          state_d = S_BRK;
          cnt_d   = BOUNCE_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_BRK: begin
        if (cnt_q == 32'd0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
      end
    endcase

    // Contact follows the phase being entered so the first chatter sample
    // appears the cycle right after accept.
    case (state_d)
      S_MAKE, S_BRK: contact_d = lfsr_d[0];
      S_HOLD:        contact_d = 1'b1;
      default:       contact_d = 1'b0;
    endcase
  end

  // Outputs: handshake/status and the combinational column-to-row switch path
  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_GAP) && (cnt_q == 32'd0);
    err       = err_q;
    key_in    = 6'b111111;
    for (int r = 0; r < 6; r++) begin
      if ((code_q < NUM_KEYS) && (code_q[4:2] == 3'(r))) begin
        key_in[r] = ~(contact_q & ~key_out[code_q[1:0]]);
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_emulator.sv
// tb/tb_key_matrix_emulator.sv - directed self-checking bench for key_matrix_emulator
module tb_key_matrix_emulator;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_out;
  logic [5:0]  key_in;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_code;
  logic [15:0] req_hold;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  key_matrix_emulator #(
    .BOUNCE_CYC(4),
    .HOLD_UNIT (8),
    .GAP_CYC   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_out  (key_out),
    .key_in   (key_in),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_code (req_code),
    .req_hold (req_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] code, input logic [15:0] hold);
    @(negedge clk);
    req_code  = code;
    req_hold  = hold;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    key_out   = 4'b1110;
    req_valid = 1'b0;
    req_code  = 5'd0;
    req_hold  = 16'd0;
    #1;
    n_checks++;
    if (key_in !== 6'b111111) begin n_fail++; $display("FAIL reset_key_in: got %b exp 111111", key_in); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    key_out = 4'b1111;
    @(negedge clk);
  endtask

  task automatic test_press;
    int dones;
    dones   = 0;
    key_out = 4'b1111;
    send(5'd5, 16'd2);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (k == 1) begin
        n_checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
          n_fail++; $display("FAIL press_busy_after_accept: busy=%b ready=%b exp 1/0", busy, req_ready);
        end
      end
      if (k == 10) begin
        key_out = 4'b1101;
        #1;
        n_checks++;
        if (key_in !== 6'b111101) begin n_fail++; $display("FAIL press_hold_col1: got %b exp 111101", key_in); end
        key_out = 4'b1110;
        #1;
        n_checks++;
        if (key_in !== 6'b111111) begin n_fail++; $display("FAIL press_hold_col0: got %b exp 111111", key_in); end
        key_out = 4'b1111;
      end
      if (k == 27) begin
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL press_done_early: got %b exp 0", done); end
      end
      if (k == 28) begin
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL press_done_at_28: got %b exp 1", done); end
      end
      if (k == 29) begin
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL press_idle_after_done: ready=%b busy=%b exp 1/0", req_ready, busy);
        end
      end
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL press_done_count: got %0d exp 1", dones); end
  endtask

  task automatic test_bounce;
    logic [15:0] m;
    do_reset();
    key_out = 4'b1101;
    send(5'd5, 16'd2);
    m = 16'hACE1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (k <= 4) begin
        if (key_in[1] !== ~m[0]) begin
          n_fail++; $display("FAIL bounce_make_%0d: got %b exp %b", k, key_in[1], ~m[0]);
        end
        m = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
      end else begin
        if (key_in[1] !== 1'b0) begin
          n_fail++; $display("FAIL bounce_hold_%0d: got %b exp 0", k, key_in[1]);
        end
      end
    end
    wait_done(20, "bounce_done");
    key_out = 4'b1111;
  endtask

  task automatic test_illegal;
    logic [3:0] cols [4];
    cols[0] = 4'b1110; cols[1] = 4'b1101; cols[2] = 4'b1011; cols[3] = 4'b0111;
    key_out = 4'b1111;
    send(5'd25, 16'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (done !== (k == 4)) begin n_fail++; $display("FAIL illegal_done_%0d: got %b exp %b", k, done, (k == 4)); end
      if (k == 1) begin
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
          n_fail++; $display("FAIL illegal_err_busy: err=%b busy=%b exp 1/1", err, busy);
        end
      end
      key_out = cols[k-1];
      #1;
      n_checks++;
      if (key_in !== 6'b111111) begin n_fail++; $display("FAIL illegal_key_in_%0d: got %b exp 111111", k, key_in); end
    end
    key_out = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || err !== 1'b1) begin
      n_fail++; $display("FAIL illegal_sticky: ready=%b err=%b exp 1/1", req_ready, err);
    end
    send(5'd0, 16'd1);
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_clear: got %b exp 0", err); end
    wait_done(40, "legal_after_illegal_done");
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    key_out = 4'b0111;
    send(5'd23, 16'd2);
    repeat (10) @(negedge clk);
    n_checks++;
    if (key_in !== 6'b011111) begin n_fail++; $display("FAIL midhold_closed: got %b exp 011111", key_in); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (key_in[5] !== 1'b1) begin n_fail++; $display("FAIL midhold_async_open: got %b exp 1", key_in[5]); end
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midhold_abort: busy=%b ready=%b exp 0/1", busy, req_ready);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    key_out = 4'b1111;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int dones;
    dones   = 0;
    key_out = 4'b1111;
    @(negedge clk);
    req_code  = 5'd5;
    req_hold  = 16'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_code = 5'd10;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        req_valid = 1'b0;
      end
      if (k == 6) begin
        key_out = 4'b1101;
        #1;
        n_checks++;
        if (key_in !== 6'b111101) begin n_fail++; $display("FAIL b2b_first_code: got %b exp 111101", key_in); end
        key_out = 4'b1011;
        #1;
        n_checks++;
        if (key_in !== 6'b111111) begin n_fail++; $display("FAIL b2b_not_requeued: got %b exp 111111", key_in); end
        key_out = 4'b1111;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL b2b_single_done: got %0d exp 1", dones); end
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: ready=%b busy=%b exp 1/0", req_ready, busy);
    end
    send(5'd10, 16'd1);
    repeat (6) @(negedge clk);
    key_out = 4'b1011;
    #1;
    n_checks++;
    if (key_in !== 6'b111011) begin n_fail++; $display("FAIL b2b_second_code: got %b exp 111011", key_in); end
    key_out = 4'b1111;
    wait_done(30, "b2b_second_done");
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_illegal();
    test_reset_mid_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
